spi_adc_i: RTL and testbench

Dual-channel SPI ADC reader: the capture-side counterpart of the SID block's SPI DAC output path. It repeatedly runs MCP3202-style conversion frames, alternating between ADC channel 0 and channel 1. Each 12-bit result is presented on a per-channel register with a one-cycle valid strobe, for use as audio/paddle input to the SID core. SPI pin timing uses the same divide-by-4 tick scheme as the DAC driver, so both share board-level SCLK rates.

---
 rtl/spi_adc_i_if.sv | 26 ++
 rtl/spi_adc_i.sv | 132 +++++++++++++
 tb/tb_spi_adc_i.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_adc_i_if.sv
// Signal bundle between the dual-channel SPI ADC reader and its host/ADC pins.
// The slave modport is the reader itself; master is the host side (plus ADC Dout).
interface spi_adc_i_if;
    logic        conv_en;
    logic        diff;
    logic        spi_miso;
    logic        spi_clk;
    logic        spi_csb;
    logic        spi_mosi;
    logic [11:0] sample_out_1;
    logic [11:0] sample_out_2;
    logic        sample_valid;
    logic        sample_chan;

    modport slave (
        input  conv_en, diff, spi_miso,
        output spi_clk, spi_csb, spi_mosi,
        output sample_out_1, sample_out_2, sample_valid, sample_chan
    );

    modport master (
        output conv_en, diff, spi_miso,
        input  spi_clk, spi_csb, spi_mosi,
        input  sample_out_1, sample_out_2, sample_valid, sample_chan
    );
endinterface

// File: rtl/spi_adc_i.sv
// Dual-channel MCP3202-style SPI ADC reader, alternating ch0/ch1 frames.
// SPI state advances once every 4 clk (tick when clkdiv wraps to 0).
module spi_adc_i (
    input logic         clk,
    input logic         rst,
    spi_adc_i_if.slave  bus
);
    typedef enum logic {S_IDLE, S_FRAME} state_t;

    localparam logic [5:0] CNT_IDLE = 6'd35;

    state_t      r_state, w_state;
    logic [1:0]  r_clkdiv;
    logic [5:0]  r_count, w_count;
    logic        r_diff, w_diff;
    logic        r_fchan, w_fchan;
    logic        r_chan, w_chan;
    logic [11:0] r_shift, w_shift;
    logic [11:0] r_out1, w_out1;
    logic [11:0] r_out2, w_out2;
    logic        r_valid, w_valid;
    logic        r_schan, w_schan;
    logic        r_sclk, w_sclk;
    logic        r_csb, w_csb;
    logic        r_mosi, w_mosi;
    logic        w_tick;

    assign w_tick = (r_clkdiv == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_clkdiv <= '0;
            r_count  <= CNT_IDLE;
            r_diff   <= 1'b0;
            r_fchan  <= 1'b0;
            r_chan   <= 1'b0;
            r_shift  <= '0;
            r_out1   <= 12'h800;
            r_out2   <= 12'h800;
            r_valid  <= 1'b0;
            r_schan  <= 1'b0;
            r_sclk   <= 1'b0;
            r_csb    <= 1'b1;
            r_mosi   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_clkdiv <= r_clkdiv + 2'd1;
            r_count  <= w_count;
            r_diff   <= w_diff;
            r_fchan  <= w_fchan;
            r_chan   <= w_chan;
            r_shift  <= w_shift;
            r_out1   <= w_out1;
            r_out2   <= w_out2;
            r_valid  <= w_valid;
            r_schan  <= w_schan;
            r_sclk   <= w_sclk;
            r_csb    <= w_csb;
            r_mosi   <= w_mosi;
        end
    end

    always_comb begin
        w_state = r_state;
        w_count = r_count;
        w_diff  = r_diff;
        w_fchan = r_fchan;
        w_chan  = r_chan;
        w_shift = r_shift;
        w_out1  = r_out1;
        w_out2  = r_out2;
        w_valid = 1'b0;
        w_schan = r_schan;
        w_sclk  = r_sclk;
        w_csb   = r_csb;
        w_mosi  = r_mosi;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    w_sclk = 1'b0;
                    w_csb  = 1'b1;
                    if (bus.conv_en) begin
                        w_diff  = bus.diff;
                        w_fchan = r_chan;
                        w_count = '0;
                        w_state = S_FRAME;
                    end
                end
                S_FRAME: begin
                    w_count = r_count + 6'd1;
                    if (r_count == 6'd34) begin
                        w_sclk  = 1'b0;
                        w_csb   = 1'b1;
                        w_mosi  = 1'b0;
                        if (r_fchan) w_out2 = r_shift;
                        else         w_out1 = r_shift;
                        w_schan = r_fchan;
                        w_valid = 1'b1;
                        w_chan  = ~r_chan;
                        w_count = CNT_IDLE;
                        w_state = S_IDLE;
                    end else if (!r_count[0]) begin
                        w_sclk = 1'b0;
                        w_csb  = 1'b0;
                        // Command bits: start, SGL/DIFF, ODD/SIGN, MSBF, then zeros
                        case (r_count[5:1])
                            5'd0:    w_mosi = 1'b1;
                            5'd1:    w_mosi = ~r_diff;
                            5'd2:    w_mosi = r_fchan;
                            5'd3:    w_mosi = 1'b1;
                            default: w_mosi = 1'b0;
                        endcase
                    end else begin
                        w_sclk = 1'b1;
                        if (r_count >= 6'd11)
                            w_shift = {r_shift[10:0], bus.spi_miso};
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    assign bus.spi_clk      = r_sclk;
    assign bus.spi_csb      = r_csb;
    assign bus.spi_mosi     = r_mosi;
    assign bus.sample_out_1 = r_out1;
    assign bus.sample_out_2 = r_out2;
    assign bus.sample_valid = r_valid;
    assign bus.sample_chan  = r_schan;
endmodule

// File: tb/tb_spi_adc_i.sv
// Directed bench for spi_adc_i with a behavioural MCP3202-style ADC model.
module tb_spi_adc_i;
    logic clk;
    logic rst;
    logic tb_conv_en;
    logic tb_diff;
    logic tb_miso;

    int n_checks;
    int n_pass;
    int edge_n;

    logic [11:0] data0;
    logic [11:0] data1;
    logic        null_bit;

    int          rcnt;
    logic [3:0]  cmd;
    logic [3:0]  last_cmd;
    logic [11:0] cur;

    spi_adc_i_if bus ();

    assign bus.conv_en  = tb_conv_en;
    assign bus.diff     = tb_diff;
    assign bus.spi_miso = tb_miso;

    spi_adc_i u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n++;

    // ADC model: samples Din on SCLK rise, updates Dout after SCLK fall
    initial begin
        rcnt     = 0;
        cmd      = '0;
        last_cmd = '0;
    end

    always @(negedge bus.spi_csb) rcnt = 0;

    always @(posedge bus.spi_clk) begin
        if (!bus.spi_csb) begin
            if (rcnt < 4) cmd = {cmd[2:0], bus.spi_mosi};
            if (rcnt == 3) last_cmd = cmd;
            rcnt++;
        end
    end

    always @(negedge bus.spi_clk) begin
        if (!bus.spi_csb) begin
            cur = last_cmd[1] ? data1 : data0;
            if (rcnt == 4)
                tb_miso = null_bit;
            else if (rcnt >= 5 && rcnt <= 16)
                tb_miso = cur[4'(16 - rcnt)];
            else
                tb_miso = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tb_miso = 1'($urandom_range(0, 1));
        end
        rst    = 1'b0;
        edge_n = 0;
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.sample_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    bit seen;
    int sclk_hi, csb_lo, vcount;

    initial begin
        rst        = 1'b1;
        tb_conv_en = 1'b0;
        tb_diff    = 1'b0;
        tb_miso    = 1'b0;
        n_checks   = 0;
        n_pass     = 0;
        edge_n     = 0;
        data0      = 12'hA5C;
        data1      = 12'h3F1;
        null_bit   = 1'b0;

        // Reset values and idle behaviour with conv_en low
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tb_miso = 1'($urandom_range(0, 1));
        end
        check("rst_csb",   32'(bus.spi_csb), 32'd1);
        check("rst_sclk",  32'(bus.spi_clk), 32'd0);
        check("rst_mosi",  32'(bus.spi_mosi), 32'd0);
        check("rst_out1",  32'(bus.sample_out_1), 32'h800);
        check("rst_out2",  32'(bus.sample_out_2), 32'h800);
        check("rst_valid", 32'(bus.sample_valid), 32'd0);
        check("rst_chan",  32'(bus.sample_chan), 32'd0);
        rst = 1'b0;
        sclk_hi = 0; csb_lo = 0; vcount = 0;
        repeat (200) begin
            @(negedge clk);
            tb_miso = 1'($urandom_range(0, 1));
            if (bus.spi_clk) sclk_hi++;
            if (!bus.spi_csb) csb_lo++;
            if (bus.sample_valid) vcount++;
        end
        check("idle_sclk", 32'(sclk_hi), 32'd0);
        check("idle_csb",  32'(csb_lo), 32'd0);
        check("idle_valid", 32'(vcount), 32'd0);

        // Basic capture, single-ended
        tb_conv_en = 1'b1;
        tb_diff    = 1'b0;
        do_reset();
        wait_valid(200, seen);
        check("b0_seen",  32'(seen), 32'd1);
        check("b0_edge",  32'(edge_n), 32'd141);
        check("b0_chan",  32'(bus.sample_chan), 32'd0);
        check("b0_out1",  32'(bus.sample_out_1), 32'hA5C);
        check("b0_out2",  32'(bus.sample_out_2), 32'h800);
        check("b0_cmd",   32'(last_cmd), 32'b1101);
        @(negedge clk);
        check("b0_vlow",  32'(bus.sample_valid), 32'd0);
        wait_valid(200, seen);
        check("b1_seen",  32'(seen), 32'd1);
        check("b1_edge",  32'(edge_n), 32'd285);
        check("b1_chan",  32'(bus.sample_chan), 32'd1);
        check("b1_out2",  32'(bus.sample_out_2), 32'h3F1);
        check("b1_out1",  32'(bus.sample_out_1), 32'hA5C);
        check("b1_cmd",   32'(last_cmd), 32'b1111);

        // Differential mode, diff toggled after latch
        tb_diff = 1'b1;
        do_reset();
        while (edge_n < 10) @(negedge clk);
        tb_diff = 1'b0;
        wait_valid(200, seen);
        check("d0_seen", 32'(seen), 32'd1);
        check("d0_cmd",  32'(last_cmd), 32'b1001);
        check("d0_out1", 32'(bus.sample_out_1), 32'hA5C);
        tb_diff = 1'b1;
        while (edge_n < 150) @(negedge clk);
        tb_diff = 1'b0;
        wait_valid(200, seen);
        check("d1_seen", 32'(seen), 32'd1);
        check("d1_cmd",  32'(last_cmd), 32'b1011);
        check("d1_out2", 32'(bus.sample_out_2), 32'h3F1);

        // Null bit set with zero data, then null clear with all-ones data
        data0    = 12'h000;
        null_bit = 1'b1;
        do_reset();
        wait_valid(200, seen);
        check("n0_seen", 32'(seen), 32'd1);
        check("n0_out1", 32'(bus.sample_out_1), 32'h000);
        null_bit = 1'b0;
        data1    = 12'hFFF;
        wait_valid(200, seen);
        check("n1_seen", 32'(seen), 32'd1);
        check("n1_out2", 32'(bus.sample_out_2), 32'hFFF);

        // Enable gating: drop conv_en mid-frame 0
        data0 = 12'h5A3;
        data1 = 12'h1C7;
        tb_conv_en = 1'b1;
        do_reset();
        while (edge_n < 84) @(negedge clk);
        tb_conv_en = 1'b0;
        wait_valid(100, seen);
        check("g0_seen", 32'(seen), 32'd1);
        check("g0_edge", 32'(edge_n), 32'd141);
        check("g0_out1", 32'(bus.sample_out_1), 32'h5A3);
        sclk_hi = 0; csb_lo = 0; vcount = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.spi_clk) sclk_hi++;
            if (!bus.spi_csb) csb_lo++;
            if (bus.sample_valid) vcount++;
        end
        check("g_sclk",  32'(sclk_hi), 32'd0);
        check("g_csb",   32'(csb_lo), 32'd0);
        check("g_valid", 32'(vcount), 32'd0);
        tb_conv_en = 1'b1;
        wait_valid(200, seen);
        check("g1_seen", 32'(seen), 32'd1);
        check("g1_chan", 32'(bus.sample_chan), 32'd1);
        check("g1_out2", 32'(bus.sample_out_2), 32'h1C7);
        check("g1_out1", 32'(bus.sample_out_1), 32'h5A3);

        // Reset pulse at counter 20
        do_reset();
        while (edge_n < 84) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        edge_n = 0;
        check("mr_csb",   32'(bus.spi_csb), 32'd1);
        check("mr_sclk",  32'(bus.spi_clk), 32'd0);
        check("mr_valid", 32'(bus.sample_valid), 32'd0);
        check("mr_out1",  32'(bus.sample_out_1), 32'h800);
        check("mr_out2",  32'(bus.sample_out_2), 32'h800);
        wait_valid(200, seen);
        check("mr_seen",  32'(seen), 32'd1);
        check("mr_edge",  32'(edge_n), 32'd141);
        check("mr_chan",  32'(bus.sample_chan), 32'd0);
        check("mr_cmd",   32'(last_cmd), 32'b1101);
        check("mr_res",   32'(bus.sample_out_1), 32'h5A3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
